amo_seq_decoder: RTL
====================

Name: amo_seq_decoder

Overview:
Registered, parametrised main control decoder for the RV32 pipeline ID stage, a successor to the combinational main decoder. Decodes RV32I plus optional M and A extensions, and registers all control outputs into ID/EX. It cracks AMO read-modify-write instructions into two sequenced micro-ops (load, then store) with an FSM. A valid/ready handshake, downstream stall and flush are supported.

Parameters:
ENABLE_M, 1, decode R-type funct7=0000001 as mul/div; when 0 those encodings are illegal
ENABLE_A, 1, decode opcode 0101111 (LR.W/SC.W/AMO*.W); when 0 that opcode is illegal
IMM_SRC_W, 3, width of ImmSrc_o (minimum 3)
RESULT_SRC_W, 3, width of ResultSrc_o (minimum 3)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
valid_i  in  1  instr_i valid from IF/ID
ready_o  out  1  decoder accepts instr_i this cycle
instr_i  in  32  instruction word
stall_i  in  1  downstream stall; hold outputs
flush_i  in  1  kill current and in-flight decode
valid_o  out  1  registered control bundle valid
RegWrite_o, MemWrite_o, MemRead_o, Branch_o, Jump_o, ALUSrc_o, MulDiv_o  out  1 each  control flags
ALUOp_o  out  2  00 add, 01 sub/branch, 10 funct-decoded, 11 AMO op from AmoFunct5_o
ImmSrc_o  out  IMM_SRC_W  000 I, 001 S, 010 B, 011 J, 100 U
ResultSrc_o  out  RESULT_SRC_W  000 ALU, 001 Mem, 010 PC+4, 011 Imm, 100 PC+Imm
AmoFunct5_o  out  5  funct5 of the current A-instruction, else 0
AmoPhase_o  out  2  00 none, 01 load, 10 store, 11 LR/SC single
Illegal_o  out  1  illegal instruction flag

Behaviour:
- Reset (async, rst_n=0): state=IDLE; valid_o=0; all control outputs, AmoFunct5_o, AmoPhase_o and Illegal_o =0. Reset mid-AMO discards the store phase.
- ready_o = (state==IDLE) && !stall_i. This path is combinational.
- Accept = valid_i && ready_o. Latency is 1 cycle: the bundle is registered on the accepting edge.
- Base decode (op -> RegWrite, ImmSrc, ALUSrc, MemWrite, ResultSrc, Branch, ALUOp, Jump):
  - lw 0000011: 1, 000, 1, 0, 001, 0, 00, 0; MemRead=1.
  - sw 0100011: 0, 001, 1, 1, 000, 0, 00, 0.
  - R-type 0110011: 1, 000, 0, 0, 000, 0, 10, 0.
  - branch 1100011: 0, 010, 0, 0, 000, 1, 01, 0.
  - I-ALU 0010011: 1, 000, 1, 0, 000, 0, 10, 0.
  - jal 1101111: 1, 011, 0, 0, 010, 0, 00, 1.
  - lui 0110111: 1, 100, 0, 0, 011, 0, 00, 0.
  - auipc 0010111: 1, 100, 0, 0, 100, 0, 00, 0.
  - fence 0001111: legal NOP, all zero.
- M extension: R-type with funct7=0000001 sets MulDiv_o=1, otherwise same as R-type.
- A extension, funct5 = instr[31:27]:
  - LR.W 00010: AmoPhase_o=11, load-type bundle, ImmSrc don't-care.
  - SC.W 00011: AmoPhase_o=11, MemWrite=1, RegWrite=1, ResultSrc=001.
  - AMO ops 00001 swap, 00000 add, 00100 xor, 01100 and, 01000 or, 10000 min, 10100 max, 11000 minu, 11100 maxu: cracked into two micro-ops.
- FSM states: IDLE, AMO_ST.
  - IDLE, accepting an AMO: emit the load micro-op (RegWrite=1, MemRead=1, ResultSrc=001, ALUSrc=0, AmoPhase_o=01). Latch funct5. Go to AMO_ST.
  - AMO_ST, when !stall_i: emit the store micro-op (MemWrite=1, RegWrite=0, ALUOp=11, AmoPhase_o=10). Go to IDLE. ready_o=0 throughout AMO_ST.
- Illegal (unknown opcode, M/A encoding with its ENABLE parameter =0, or undefined funct5): valid_o=1, Illegal_o=1, all other controls 0.
- Stall: while stall_i=1, the output register and state hold. A new instruction is not accepted.
- Flush: synchronous, highest priority over stall and accept. Next cycle valid_o=0, controls=0, state=IDLE.
- No accept and no stall: valid_o=0 next cycle (bubble). Controls are zeroed.

Decomposition:
- Shared package/include: opcode constants, funct5 AMO codes, and ImmSrc/ResultSrc/ALUOp/AmoPhase encodings.
- One natural sub-module: main_decoder_comb, the pure combinational op/funct -> bundle decode. The top holds the FSM, the handshake and the output register.

Test Plan:
- Reset then lw 0x00012083 with valid_i=1 -> next cycle valid_o=1, RegWrite=1, ALUSrc=1, ResultSrc=001, MemRead=1, ImmSrc=000.
- amoadd.w 0x0020A1AF -> cycle1: AmoPhase=01, MemRead=1, RegWrite=1; cycle2: AmoPhase=10, MemWrite=1, ALUOp=11, AmoFunct5=00000; ready_o=0 during cycle1.
- Same AMO with stall_i=1 held for 3 cycles after the load phase -> load bundle held 3 cycles, then the store bundle is emitted.
- flush_i=1 in AMO_ST -> next cycle valid_o=0, ready_o=1, no store micro-op.
- ENABLE_M=0, mul 0x022081B3 -> Illegal_o=1, RegWrite=0. With ENABLE_M=1 -> MulDiv_o=1, ALUOp=10.
- rst_n low mid-AMO (asynchronous, between edges) -> outputs 0 immediately; after release, lui 0x000120B7 -> ImmSrc=100, ResultSrc=011.

Source files
------------

// File: rtl/amo_seq_decoder_pkg.sv
// Shared encodings for the registered RV32 main decoder: opcodes, AMO funct5
// codes, control-field enums and the control bundle carried into ID/EX.
package amo_seq_decoder_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_AMO    = 7'b0101111;

  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam logic [4:0] F5_LR   = 5'b00010;
  localparam logic [4:0] F5_SC   = 5'b00011;
  localparam logic [4:0] F5_SWAP = 5'b00001;
  localparam logic [4:0] F5_ADD  = 5'b00000;
  localparam logic [4:0] F5_XOR  = 5'b00100;
  localparam logic [4:0] F5_AND  = 5'b01100;
  localparam logic [4:0] F5_OR   = 5'b01000;
  localparam logic [4:0] F5_MIN  = 5'b10000;
  localparam logic [4:0] F5_MAX  = 5'b10100;
  localparam logic [4:0] F5_MINU = 5'b11000;
  localparam logic [4:0] F5_MAXU = 5'b11100;

  typedef enum logic [2:0] {
    IMM_I = 3'b000, IMM_S = 3'b001, IMM_B = 3'b010, IMM_J = 3'b011, IMM_U = 3'b100
  } imm_src_e;

  typedef enum logic [2:0] {
    RES_ALU = 3'b000, RES_MEM = 3'b001, RES_PC4 = 3'b010, RES_IMM = 3'b011, RES_PCIMM = 3'b100
  } result_src_e;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00, ALU_SUB = 2'b01, ALU_FUNCT = 2'b10, ALU_AMO = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    PH_NONE = 2'b00, PH_LOAD = 2'b01, PH_STORE = 2'b10, PH_SINGLE = 2'b11
  } amo_phase_e;

  typedef struct packed {
    logic        reg_write;
    logic        mem_write;
    logic        mem_read;
    logic        branch;
    logic        jump;
    logic        alu_src;
    logic        mul_div;
    alu_op_e     alu_op;
    imm_src_e    imm_src;
    result_src_e result_src;
    logic [4:0]  amo_funct5;
    amo_phase_e  amo_phase;
    logic        illegal;
  } ctrl_t;

  // Read-modify-write AMOs are the ones cracked into a load and a store.
  function automatic logic is_amo_rmw(input logic [4:0] f5);
    logic r;
    case (f5)
      F5_SWAP, F5_ADD, F5_XOR, F5_AND, F5_OR,
      F5_MIN, F5_MAX, F5_MINU, F5_MAXU: r = 1'b1;
      default:                          r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic ctrl_t amo_store_bundle(input logic [4:0] f5);
    ctrl_t c;
    c            = '0;
    c.mem_write  = 1'b1;
    c.alu_op     = ALU_AMO;
    c.amo_phase  = PH_STORE;
    c.amo_funct5 = f5;
    return c;
  endfunction

endpackage

// File: rtl/amo_seq_decoder_main_decoder_comb.sv
// Pure combinational opcode/funct -> control bundle decode for RV32I[M][A].
// For cracked AMOs it returns the load micro-op and raises amo_rmw_o.
module main_decoder_comb
  import amo_seq_decoder_pkg::*;
#(
  parameter bit ENABLE_M = 1'b1,
  parameter bit ENABLE_A = 1'b1
) (
  input  logic [31:0] instr_i,
  output ctrl_t       ctrl_o,
  output logic        amo_rmw_o
);

  logic [6:0] opcode_s;
  logic [6:0] funct7_s;
  logic [4:0] funct5_s;
  logic       unused_fields_s;
  ctrl_t      ctrl_s;
  logic       amo_rmw_s;
  logic       illegal_s;

  assign opcode_s        = instr_i[6:0];
  assign funct7_s        = instr_i[31:25];
  assign funct5_s        = instr_i[31:27];
  assign unused_fields_s = ^instr_i[24:7];

  // Opcode decode; any illegal encoding collapses to a bare Illegal bundle below.
  always_comb begin
    ctrl_s    = '0;
    amo_rmw_s = 1'b0;
    illegal_s = 1'b0;
    case (opcode_s)
      OP_LOAD: begin
        ctrl_s.reg_write  = 1'b1;
        ctrl_s.alu_src    = 1'b1;
        ctrl_s.mem_read   = 1'b1;
        ctrl_s.result_src = RES_MEM;
      end
      OP_STORE: begin
        ctrl_s.imm_src   = IMM_S;
        ctrl_s.alu_src   = 1'b1;
        ctrl_s.mem_write = 1'b1;
      end
      OP_RTYPE: begin
        ctrl_s.reg_write = 1'b1;
        ctrl_s.alu_op    = ALU_FUNCT;
        if (funct7_s == F7_MULDIV) begin
          if (ENABLE_M) begin
            ctrl_s.mul_div = 1'b1;
          end else begin
            illegal_s = 1'b1;
          end
        end else begin
          ctrl_s.mul_div = 1'b0;
        end
      end
      OP_BRANCH: begin
        ctrl_s.imm_src = IMM_B;
        ctrl_s.branch  = 1'b1;
        ctrl_s.alu_op  = ALU_SUB;
      end
      OP_IALU: begin
        ctrl_s.reg_write = 1'b1;
        ctrl_s.alu_src   = 1'b1;
        ctrl_s.alu_op    = ALU_FUNCT;
      end
      OP_JAL: begin
        ctrl_s.reg_write  = 1'b1;
        ctrl_s.imm_src    = IMM_J;
        ctrl_s.result_src = RES_PC4;
        ctrl_s.jump       = 1'b1;
      end
      OP_LUI: begin
        ctrl_s.reg_write  = 1'b1;
        ctrl_s.imm_src    = IMM_U;
        ctrl_s.result_src = RES_IMM;
      end
      OP_AUIPC: begin
        ctrl_s.reg_write  = 1'b1;
        ctrl_s.imm_src    = IMM_U;
        ctrl_s.result_src = RES_PCIMM;
      end
      OP_FENCE: begin
        ctrl_s = '0;
      end
      OP_AMO: begin
        if (!ENABLE_A) begin
          illegal_s = 1'b1;
        end else begin
          ctrl_s.amo_funct5 = funct5_s;
          ctrl_s.reg_write  = 1'b1;
          ctrl_s.result_src = RES_MEM;
          case (funct5_s)
            F5_LR: begin
              ctrl_s.mem_read  = 1'b1;
              ctrl_s.alu_src   = 1'b1;
              ctrl_s.amo_phase = PH_SINGLE;
            end
            F5_SC: begin
              ctrl_s.mem_write = 1'b1;
              ctrl_s.amo_phase = PH_SINGLE;
            end
            default: begin
              if (is_amo_rmw(funct5_s)) begin
                ctrl_s.mem_read  = 1'b1;
                ctrl_s.amo_phase = PH_LOAD;
                amo_rmw_s        = 1'b1;
              end else begin
                illegal_s = 1'b1;
              end
            end
          endcase
        end
      end
      default: begin
        illegal_s = 1'b1;
      end
    endcase
  end

  // Illegal instructions carry no side effects: only the Illegal flag survives.
  always_comb begin
    ctrl_o    = '0;
    amo_rmw_o = 1'b0;
    if (illegal_s) begin
      ctrl_o.illegal = 1'b1;
    end else begin
      ctrl_o    = ctrl_s;
      amo_rmw_o = amo_rmw_s;
    end
  end

endmodule

// File: rtl/amo_seq_decoder.sv
// Registered ID-stage main decoder: valid/ready handshake, stall/flush, and
// an FSM that sequences cracked AMOs as a load micro-op then a store micro-op.
module amo_seq_decoder
  import amo_seq_decoder_pkg::*;
#(
  parameter bit          ENABLE_M     = 1'b1,
  parameter bit          ENABLE_A     = 1'b1,
  parameter int unsigned IMM_SRC_W    = 3,
  parameter int unsigned RESULT_SRC_W = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    valid_i,
  output logic                    ready_o,
  input  logic [31:0]             instr_i,
  input  logic                    stall_i,
  input  logic                    flush_i,
  output logic                    valid_o,
  output logic                    RegWrite_o,
  output logic                    MemWrite_o,
  output logic                    MemRead_o,
  output logic                    Branch_o,
  output logic                    Jump_o,
  output logic                    ALUSrc_o,
  output logic                    MulDiv_o,
  output logic [1:0]              ALUOp_o,
  output logic [IMM_SRC_W-1:0]    ImmSrc_o,
  output logic [RESULT_SRC_W-1:0] ResultSrc_o,
  output logic [4:0]              AmoFunct5_o,
  output logic [1:0]              AmoPhase_o,
  output logic                    Illegal_o
);

  typedef enum logic {ST_IDLE = 1'b0, ST_AMO = 1'b1} state_e;

  state_e     state_q, state_d;
  logic       valid_q, valid_d;
  ctrl_t      bundle_q, bundle_d;
  logic [4:0] funct5_q, funct5_d;
  ctrl_t      dec_s;
  logic       dec_amo_s;
  logic       accept_s;

  main_decoder_comb #(
    .ENABLE_M (ENABLE_M),
    .ENABLE_A (ENABLE_A)
  ) u_dec (
    .instr_i   (instr_i),
    .ctrl_o    (dec_s),
    .amo_rmw_o (dec_amo_s)
  );

  assign ready_o  = (state_q == ST_IDLE) && !stall_i;
  assign accept_s = valid_i && ready_o;

  // Next state and next bundle; flush beats stall, stall beats accept.
  always_comb begin
    state_d  = state_q;
    valid_d  = valid_q;
    bundle_d = bundle_q;
    funct5_d = funct5_q;
    if (flush_i) begin
      state_d  = ST_IDLE;
      valid_d  = 1'b0;
      bundle_d = '0;
    end else if (stall_i) begin
      state_d  = state_q;
      valid_d  = valid_q;
      bundle_d = bundle_q;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept_s) begin
            valid_d  = 1'b1;
            bundle_d = dec_s;
            if (dec_amo_s) begin
              state_d  = ST_AMO;
              funct5_d = dec_s.amo_funct5;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            valid_d  = 1'b0;
            bundle_d = '0;
          end
        end
        ST_AMO: begin
          valid_d  = 1'b1;
          bundle_d = amo_store_bundle(funct5_q);
          state_d  = ST_IDLE;
        end
        default: begin
          state_d  = ST_IDLE;
          valid_d  = 1'b0;
          bundle_d = '0;
        end
      endcase
    end
  end

  // State and ID/EX output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      valid_q  <= 1'b0;
      bundle_q <= '0;
      funct5_q <= 5'b00000;
    end else begin
      state_q  <= state_d;
      valid_q  <= valid_d;
      bundle_q <= bundle_d;
      funct5_q <= funct5_d;
    end
  end

  assign valid_o     = valid_q;
  assign RegWrite_o  = bundle_q.reg_write;
  assign MemWrite_o  = bundle_q.mem_write;
  assign MemRead_o   = bundle_q.mem_read;
  assign Branch_o    = bundle_q.branch;
  assign Jump_o      = bundle_q.jump;
  assign ALUSrc_o    = bundle_q.alu_src;
  assign MulDiv_o    = bundle_q.mul_div;
  assign ALUOp_o     = bundle_q.alu_op;
  assign ImmSrc_o    = IMM_SRC_W'(bundle_q.imm_src);
  assign ResultSrc_o = RESULT_SRC_W'(bundle_q.result_src);
  assign AmoFunct5_o = bundle_q.amo_funct5;
  assign AmoPhase_o  = bundle_q.amo_phase;
  assign Illegal_o   = bundle_q.illegal;

endmodule
